// File: rtl/hud_text_server.sv
`default_nettype none
// ============================================================================
//  Module      : hud_text_server
//  Description : HUD text-pixel responder. Renders "TIME:" with a 3-digit BCD
//                play-time counter and "SCORE:" with a 4-digit BCD score,
//                one registered pixel bit per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module hud_text_server #(
    parameter int TICKS_PER_SEC = 25_000_000,
    parameter int TIME_DIGITS   = 3,
    parameter int SCORE_DIGITS  = 4
) (
    input  logic                        clock_25,
    input  logic                        reset_n,
    input  logic [7:0]                  x_count,
    input  logic [3:0]                  y_count,
    input  logic                        game_run,
    input  logic                        time_clear,
    input  logic                        score_clear,
    input  logic                        score_inc,
    output logic                        data,
    output logic [4*TIME_DIGITS-1:0]    time_bcd,
    output logic [4*SCORE_DIGITS-1:0]   score_bcd
);

    localparam int TIME_W  = 4 * TIME_DIGITS;
    localparam int SCORE_W = 4 * SCORE_DIGITS;
    localparam int PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PRESC_W-1:0] C_PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

    localparam logic [4:0] C_CODE_T     = 5'd10;
    localparam logic [4:0] C_CODE_I     = 5'd11;
    localparam logic [4:0] C_CODE_M     = 5'd12;
    localparam logic [4:0] C_CODE_E     = 5'd13;
    localparam logic [4:0] C_CODE_S     = 5'd14;
    localparam logic [4:0] C_CODE_C     = 5'd15;
    localparam logic [4:0] C_CODE_O     = 5'd16;
    localparam logic [4:0] C_CODE_R     = 5'd17;
    localparam logic [4:0] C_CODE_COLON = 5'd18;
    localparam logic [4:0] C_CODE_BLANK = 5'd19;

    // Glyph bitmap: 15 row bytes, row 0 in the top byte, MSB = leftmost column.
    function automatic logic [119:0] glyph(input logic [4:0] code);
        logic [119:0] g;
        case (code)
            5'd0:  g = 120'h00_7C_C6_C6_CE_DE_F6_E6_C6_C6_C6_7C_00_00_00;
            5'd1:  g = 120'h00_18_38_78_18_18_18_18_18_18_18_7E_00_00_00;
            5'd2:  g = 120'h00_7C_C6_06_0C_18_30_60_C0_C0_C6_FE_00_00_00;
            5'd3:  g = 120'h00_7C_C6_06_06_3C_06_06_06_06_C6_7C_00_00_00;
            5'd4:  g = 120'h00_0C_1C_3C_6C_CC_FE_0C_0C_0C_0C_1E_00_00_00;
            5'd5:  g = 120'h00_FE_C0_C0_C0_FC_06_06_06_06_C6_7C_00_00_00;
            5'd6:  g = 120'h00_38_60_C0_C0_FC_C6_C6_C6_C6_C6_7C_00_00_00;
            5'd7:  g = 120'h00_FE_C6_06_0C_18_30_30_30_30_30_30_00_00_00;
            5'd8:  g = 120'h00_7C_C6_C6_C6_7C_C6_C6_C6_C6_C6_7C_00_00_00;
            5'd9:  g = 120'h00_7C_C6_C6_C6_7E_06_06_06_0C_18_70_00_00_00;
            5'd10: g = 120'h00_FE_FE_38_38_38_38_38_38_38_38_38_00_00_00;
            5'd11: g = 120'h00_7C_38_38_38_38_38_38_38_38_38_7C_00_00_00;
            5'd12: g = 120'h00_C6_EE_FE_FE_D6_C6_C6_C6_C6_C6_C6_00_00_00;
            5'd13: g = 120'h00_FE_C0_C0_C0_FC_C0_C0_C0_C0_C0_FE_00_00_00;
            5'd14: g = 120'h00_7C_C6_C0_C0_7C_06_06_06_06_C6_7C_00_00_00;
            5'd15: g = 120'h00_7C_C6_C0_C0_C0_C0_C0_C0_C0_C6_7C_00_00_00;
            5'd16: g = 120'h00_7C_C6_C6_C6_C6_C6_C6_C6_C6_C6_7C_00_00_00;
            5'd17: g = 120'h00_FC_C6_C6_C6_FC_D8_CC_CC_C6_C6_C6_00_00_00;
            5'd18: g = 120'h00_00_00_18_18_00_00_00_00_18_18_00_00_00_00;
            default: g = '0;
        endcase
        return g;
    endfunction

    // BCD +1 over the low 'digits' nibbles; an all-nines value is held.
    function automatic logic [15:0] bcd_inc_sat(input logic [15:0] v, input int digits);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry && (i < digits)) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return carry ? v : r;
    endfunction

    logic                 data_q,  data_d;
    logic [TIME_W-1:0]    time_q,  time_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;

    logic                 w_tick;
    logic [15:0]          w_time_inc;
    logic [15:0]          w_score_inc;
    logic [7:0]           w_score_off;
    logic [4:0]           w_code;
    logic [2:0]           w_col;
    logic                 w_in_range;
    logic [3:0]           w_row_idx;
    logic [119:0]         w_glyph;
    logic [7:0]           w_row_word;

    assign w_tick      = game_run && (presc_q == C_PRESC_LAST);
    assign w_time_inc  = bcd_inc_sat(16'(time_q), TIME_DIGITS);
    assign w_score_inc = bcd_inc_sat(16'(score_q), SCORE_DIGITS);
    assign w_score_off = x_count - 8'd62;

    always_comb begin
        w_code     = C_CODE_BLANK;
        w_col      = 3'd0;
        w_in_range = 1'b0;
        if (x_count < 8'd62) begin
            w_in_range = 1'b1;
            w_col      = x_count[2:0];
            case (x_count[7:3])
                5'd0:    w_code = C_CODE_T;
                5'd1:    w_code = C_CODE_I;
                5'd2:    w_code = C_CODE_M;
                5'd3:    w_code = C_CODE_E;
                5'd4:    w_code = C_CODE_COLON;
                5'd5:    w_code = {1'b0, time_q[11:8]};
                5'd6:    w_code = {1'b0, time_q[7:4]};
                5'd7:    w_code = {1'b0, time_q[3:0]};
                default: w_code = C_CODE_BLANK;
            endcase
        end else if (x_count <= 8'd141) begin
            w_in_range = 1'b1;
            w_col      = w_score_off[2:0];
            case (w_score_off[7:3])
                5'd0:    w_code = C_CODE_S;
                5'd1:    w_code = C_CODE_C;
                5'd2:    w_code = C_CODE_O;
                5'd3:    w_code = C_CODE_R;
                5'd4:    w_code = C_CODE_E;
                5'd5:    w_code = C_CODE_COLON;
                5'd6:    w_code = {1'b0, score_q[15:12]};
                5'd7:    w_code = {1'b0, score_q[11:8]};
                5'd8:    w_code = {1'b0, score_q[7:4]};
                5'd9:    w_code = {1'b0, score_q[3:0]};
                default: w_code = C_CODE_BLANK;
            endcase
        end
    end

    // Row 15 is outside the 15-row glyph; clamp the index and blank it below.
    assign w_row_idx  = (y_count == 4'd15) ? 4'd14 : y_count;
    assign w_glyph    = glyph(w_code);
    assign w_row_word = w_glyph[{(4'd14 - w_row_idx), 3'b000} +: 8];

    always_comb begin
        data_d = 1'b0;
        if (w_in_range && (y_count != 4'd15) && (w_col != 3'd7)) begin
            data_d = w_row_word[3'd7 - w_col];
        end
    end

    always_comb begin
        presc_d = presc_q;
        time_d  = time_q;
        score_d = score_q;
        if (time_clear) begin
            presc_d = '0;
            time_d  = '0;
        end else begin
            if (game_run) begin
                presc_d = w_tick ? '0 : presc_q + 1'b1;
            end
            if (w_tick) begin
                time_d = w_time_inc[TIME_W-1:0];
            end
        end
        if (score_clear) begin
            score_d = '0;
        end else if (score_inc) begin
            score_d = w_score_inc[SCORE_W-1:0];
        end
    end

    always_ff @(posedge clock_25 or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= 1'b0;
            time_q  <= '0;
            score_q <= '0;
            presc_q <= '0;
        end else begin
            data_q  <= data_d;
            time_q  <= time_d;
            score_q <= score_d;
            presc_q <= presc_d;
        end
    end

    assign data      = data_q;
    assign time_bcd  = time_q;
    assign score_bcd = score_q;

endmodule
`default_nettype wire

// File: tb/tb_hud_text_server.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hud_text_server
//  Description : Directed self-checking bench for hud_text_server.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hud_text_server;

    logic        clk;
    logic        rst_n;
    logic [7:0]  x_count;
    logic [3:0]  y_count;
    logic        game_run;
    logic        time_clear;
    logic        score_clear;
    logic        score_inc;
    logic        data;
    logic [11:0] time_bcd;
    logic [15:0] score_bcd;

    int n_checks = 0;
    int n_fail   = 0;

    // Font rows used for expectations: 'T' glyph, and row 7 of '0','4','2'.
    logic [7:0] font_t [15] = '{8'h00, 8'hFE, 8'hFE, 8'h38, 8'h38, 8'h38, 8'h38, 8'h38,
                                8'h38, 8'h38, 8'h38, 8'h38, 8'h00, 8'h00, 8'h00};
    logic [7:0] row7_zero = 8'hE6;
    logic [7:0] row7_four = 8'h0C;
    logic [7:0] row7_two  = 8'h60;

    hud_text_server #(
        .TICKS_PER_SEC (4),
        .TIME_DIGITS   (3),
        .SCORE_DIGITS  (4)
    ) dut (
        .clock_25    (clk),
        .reset_n     (rst_n),
        .x_count     (x_count),
        .y_count     (y_count),
        .game_run    (game_run),
        .time_clear  (time_clear),
        .score_clear (score_clear),
        .score_inc   (score_inc),
        .data        (data),
        .time_bcd    (time_bcd),
        .score_bcd   (score_bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            x_count   = 8'(i * 9);
            y_count   = 4'(i + 1);
            game_run  = 1'b1;
            score_inc = i[0];
            step();
        end
        n_checks++;
        if (data !== 1'b0) begin
            n_fail++; $display("FAIL reset_data: got %b want 0", data);
        end
        n_checks++;
        if (time_bcd !== 12'h000) begin
            n_fail++; $display("FAIL reset_time: got %h want 000", time_bcd);
        end
        n_checks++;
        if (score_bcd !== 16'h0000) begin
            n_fail++; $display("FAIL reset_score: got %h want 0000", score_bcd);
        end
        game_run  = 1'b0;
        score_inc = 1'b0;
        x_count   = 8'd200;
        y_count   = 4'd0;
        #4 rst_n = 1'b1;
        step();
        n_checks++;
        if ($isunknown({data, time_bcd, score_bcd}) || data !== 1'b0 ||
            time_bcd !== 12'h000 || score_bcd !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_release: got data=%b time=%h score=%h want 0/000/0000",
                     data, time_bcd, score_bcd);
        end
    endtask

    task automatic test_glyph();
        logic exp;
        x_count = 8'd0;
        for (int y = 0; y < 15; y++) begin
            y_count = 4'(y);
            step();
            exp = font_t[y][7];
            n_checks++;
            if (data !== exp) begin
                n_fail++; $display("FAIL glyph_T_col0 y=%0d: got %b want %b", y, data, exp);
            end
        end
        x_count = 8'd0; y_count = 4'd15; step();
        n_checks++;
        if (data !== 1'b0) begin
            n_fail++; $display("FAIL glyph_row15: got %b want 0", data);
        end
        x_count = 8'd7; y_count = 4'd1; step();
        n_checks++;
        if (data !== 1'b0) begin
            n_fail++; $display("FAIL glyph_col7: got %b want 0", data);
        end
        x_count = 8'd150; y_count = 4'd1; step();
        n_checks++;
        if (data !== 1'b0) begin
            n_fail++; $display("FAIL glyph_x150: got %b want 0", data);
        end
        // Hundreds digit of time is '0': row 2 = C6, column 0 lit.
        x_count = 8'd40; y_count = 4'd2; step();
        n_checks++;
        if (data !== 1'b1) begin
            n_fail++; $display("FAIL glyph_time_digit: got %b want 1", data);
        end
        // 'S' row 1 = 7C, column 1 lit.
        x_count = 8'd63; y_count = 4'd1; step();
        n_checks++;
        if (data !== 1'b1) begin
            n_fail++; $display("FAIL glyph_S_col1: got %b want 1", data);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] xs [5] = '{8'd0, 8'd2, 8'd7, 8'd3, 8'd150};
        logic       es [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        y_count = 4'd3;
        for (int i = 0; i < 5; i++) begin
            x_count = xs[i];
            step();
            n_checks++;
            if (data !== es[i]) begin
                n_fail++; $display("FAIL b2b x=%0d: got %b want %b", xs[i], data, es[i]);
            end
        end
    endtask

    task automatic test_time_count();
        game_run = 1'b0;
        time_clear = 1'b1; step(); time_clear = 1'b0;
        game_run = 1'b1;
        repeat (39) step();
        n_checks++;
        if (time_bcd !== 12'h009) begin
            n_fail++; $display("FAIL time_39cyc: got %h want 009", time_bcd);
        end
        step();
        n_checks++;
        if (time_bcd !== 12'h010) begin
            n_fail++; $display("FAIL time_40cyc: got %h want 010", time_bcd);
        end
        game_run = 1'b0;
    endtask

    task automatic test_time_stall();
        time_clear = 1'b1; step(); time_clear = 1'b0;
        game_run = 1'b1; repeat (2) step();
        game_run = 1'b0; repeat (2) step();
        game_run = 1'b1; step();
        n_checks++;
        if (time_bcd !== 12'h000) begin
            n_fail++; $display("FAIL time_stall_hold: got %h want 000", time_bcd);
        end
        step();
        n_checks++;
        if (time_bcd !== 12'h001) begin
            n_fail++; $display("FAIL time_stall_tick: got %h want 001", time_bcd);
        end
        game_run = 1'b0;
    endtask

    task automatic test_time_saturate();
        time_clear = 1'b1; step(); time_clear = 1'b0;
        game_run = 1'b1;
        repeat (3995) step();
        n_checks++;
        if (time_bcd !== 12'h998) begin
            n_fail++; $display("FAIL time_998: got %h want 998", time_bcd);
        end
        step();
        n_checks++;
        if (time_bcd !== 12'h999) begin
            n_fail++; $display("FAIL time_999: got %h want 999", time_bcd);
        end
        repeat (20) step();
        n_checks++;
        if (time_bcd !== 12'h999) begin
            n_fail++; $display("FAIL time_saturate: got %h want 999", time_bcd);
        end
        game_run = 1'b0;
    endtask

    task automatic test_time_priority();
        time_clear = 1'b1; step(); time_clear = 1'b0;
        game_run = 1'b1;
        repeat (4) step();
        n_checks++;
        if (time_bcd !== 12'h001) begin
            n_fail++; $display("FAIL time_prio_pre: got %h want 001", time_bcd);
        end
        repeat (3) step();
        time_clear = 1'b1; step(); time_clear = 1'b0;
        n_checks++;
        if (time_bcd !== 12'h000) begin
            n_fail++; $display("FAIL time_prio_clear: got %h want 000", time_bcd);
        end
        repeat (3) step();
        n_checks++;
        if (time_bcd !== 12'h000) begin
            n_fail++; $display("FAIL time_prio_prescaler: got %h want 000", time_bcd);
        end
        step();
        n_checks++;
        if (time_bcd !== 12'h001) begin
            n_fail++; $display("FAIL time_prio_after: got %h want 001", time_bcd);
        end
        game_run = 1'b0;
    endtask

    task automatic test_score();
        score_clear = 1'b1; step(); score_clear = 1'b0;
        score_inc = 1'b1; repeat (99) step(); score_inc = 1'b0;
        n_checks++;
        if (score_bcd !== 16'h0099) begin
            n_fail++; $display("FAIL score_0099: got %h want 0099", score_bcd);
        end
        score_inc = 1'b1; repeat (100) step(); score_inc = 1'b0;
        n_checks++;
        if (score_bcd !== 16'h0199) begin
            n_fail++; $display("FAIL score_0199: got %h want 0199", score_bcd);
        end
        score_inc = 1'b1; repeat (800) step(); score_inc = 1'b0;
        n_checks++;
        if (score_bcd !== 16'h0999) begin
            n_fail++; $display("FAIL score_0999: got %h want 0999", score_bcd);
        end
        score_inc = 1'b1; step(); score_inc = 1'b0;
        n_checks++;
        if (score_bcd !== 16'h1000) begin
            n_fail++; $display("FAIL score_1000: got %h want 1000", score_bcd);
        end
        score_inc = 1'b1; repeat (8999) step(); score_inc = 1'b0;
        n_checks++;
        if (score_bcd !== 16'h9999) begin
            n_fail++; $display("FAIL score_9999: got %h want 9999", score_bcd);
        end
        score_inc = 1'b1; step(); score_inc = 1'b0;
        n_checks++;
        if (score_bcd !== 16'h9999) begin
            n_fail++; $display("FAIL score_saturate: got %h want 9999", score_bcd);
        end
        score_inc = 1'b1; score_clear = 1'b1; step();
        score_inc = 1'b0; score_clear = 1'b0;
        n_checks++;
        if (score_bcd !== 16'h0000) begin
            n_fail++; $display("FAIL score_prio_clear: got %h want 0000", score_bcd);
        end
        n_checks++;
        if (time_bcd !== 12'h001) begin
            n_fail++; $display("FAIL score_clear_time_indep: got %h want 001", time_bcd);
        end
        score_inc = 1'b1; step(); score_inc = 1'b0;
        n_checks++;
        if (score_bcd !== 16'h0001) begin
            n_fail++; $display("FAIL score_after_clear: got %h want 0001", score_bcd);
        end
    endtask

    task automatic test_digit_render();
        logic [7:0] row;
        logic       exp;
        int         s;
        score_clear = 1'b1; step(); score_clear = 1'b0;
        score_inc = 1'b1; repeat (42) step(); score_inc = 1'b0;
        n_checks++;
        if (score_bcd !== 16'h0042) begin
            n_fail++; $display("FAIL render_score_value: got %h want 0042", score_bcd);
        end
        y_count = 4'd7;
        for (int x = 62; x <= 141; x++) begin
            x_count = 8'(x);
            step();
            s = x - 62;
            if (s >= 48) begin
                row = (s / 8 == 8) ? row7_four : (s / 8 == 9) ? row7_two : row7_zero;
                exp = (s % 8 == 7) ? 1'b0 : row[7 - (s % 8)];
                n_checks++;
                if (data !== exp) begin
                    n_fail++; $display("FAIL render_digit x=%0d: got %b want %b", x, data, exp);
                end
            end
        end
        x_count = 8'd110; step();
        n_checks++;
        if (data !== 1'b1) begin
            n_fail++; $display("FAIL render_pre_reset: got %b want 1", data);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (data !== 1'b0 || score_bcd !== 16'h0000 || time_bcd !== 12'h000) begin
            n_fail++;
            $display("FAIL render_async_reset: got data=%b score=%h time=%h want 0/0000/000",
                     data, score_bcd, time_bcd);
        end
        #2 rst_n = 1'b1;
        step();
        n_checks++;
        if (data !== 1'b1) begin
            n_fail++; $display("FAIL render_after_reset: got %b want 1", data);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        x_count     = 8'd0;
        y_count     = 4'd0;
        game_run    = 1'b0;
        time_clear  = 1'b0;
        score_clear = 1'b0;
        score_inc   = 1'b0;
        test_reset();
        test_glyph();
        test_back_to_back();
        test_time_count();
        test_time_stall();
        test_time_saturate();
        test_time_priority();
        test_score();
        test_digit_render();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
